// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, fetch FSM states and
// opcode-length helpers used by the fetch stage and the decoder.
package cpu_pkg;

   localparam logic [7:0] LDA_IMM = 8'h86;
   localparam logic [7:0] LDA_DIR = 8'h87;
   localparam logic [7:0] LDB_IMM = 8'h88;
   localparam logic [7:0] LDB_DIR = 8'h89;
   localparam logic [7:0] STA_DIR = 8'h96;
   localparam logic [7:0] STB_DIR = 8'h97;
   localparam logic [7:0] BRA     = 8'h20;
   localparam logic [7:0] BMI     = 8'h21;
   localparam logic [7:0] BPL     = 8'h22;
   localparam logic [7:0] BEQ     = 8'h23;
   localparam logic [7:0] BNE     = 8'h24;
   localparam logic [7:0] BVS     = 8'h25;
   localparam logic [7:0] BVC     = 8'h26;
   localparam logic [7:0] BCS     = 8'h27;
   localparam logic [7:0] BCC     = 8'h28;
   localparam logic [7:0] ADD_AB  = 8'h42;
   localparam logic [7:0] SUB_AB  = 8'h43;
   localparam logic [7:0] AND_AB  = 8'h44;
   localparam logic [7:0] OR_AB   = 8'h45;
   localparam logic [7:0] INCA    = 8'h46;
   localparam logic [7:0] INCB    = 8'h47;
   localparam logic [7:0] DECA    = 8'h48;
   localparam logic [7:0] DECB    = 8'h49;

   typedef enum logic [1:0] {
      FETCH_OP   = 2'd0,
      FETCH_OPND = 2'd1,
      HOLD       = 2'd2
   } fetch_state_e;

   function automatic logic op_is_2byte(logic [7:0] op);
      case (op)
         LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR,
         STA_DIR, STB_DIR,
         BRA, BMI, BPL, BEQ, BNE,
         BVS, BVC, BCS, BCC:       return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_legal(logic [7:0] op);
      case (op)
         ADD_AB, SUB_AB, AND_AB, OR_AB,
         INCA, INCB, DECA, DECB:   return 1'b1;
         default:                  return op_is_2byte(op);
      endcase
   endfunction

endpackage

// File: rtl/opcode_len_decode.sv
// Combinational opcode classifier: instruction length and legality.
// Shared with the decode stage so both agree on the opcode table.
module opcode_len_decode
   import cpu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic       len2,
   output logic       legal
);

   assign len2  = op_is_2byte(opcode);
   assign legal = op_is_legal(opcode);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads opcode/operand bytes
// from the combinational ROM and presents one bundle at a time.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              ADDR_W   = 7,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [7:0]        rom_data,
   output logic [PC_W-1:0]   pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        opcode,
   output logic [7:0]        operand,
   output logic              instr_len2,
   output logic [PC_W-1:0]   instr_pc,
   output logic              illegal,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ipc_q, ipc_d;
   logic [7:0]      op_q, op_d;
   logic [7:0]      opnd_q, opnd_d;
   logic            len2_q, len2_d;
   logic            ill_q, ill_d;
   logic            dec_len2;
   logic            dec_legal;

   // Classify the byte on the ROM bus; only used while in FETCH_OP.
   opcode_len_decode u_dec (
      .opcode (rom_data),
      .len2   (dec_len2),
      .legal  (dec_legal)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      len2_d  = len2_q;
      ill_d   = ill_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         state_d = FETCH_OP;
      end else begin
         unique case (state_q)
            FETCH_OP: begin
               op_d   = rom_data;
               ipc_d  = pc_q;
               pc_d   = pc_q + PC_ONE;
               len2_d = dec_len2;
               ill_d  = ~dec_legal;
               if (dec_len2) begin
                  state_d = FETCH_OPND;
               end else begin
                  opnd_d  = 8'h00;
                  state_d = HOLD;
               end
            end
            FETCH_OPND: begin
               opnd_d  = rom_data;
               pc_d    = pc_q + PC_ONE;
               state_d = HOLD;
            end
            HOLD: begin
               if (instr_ready) state_d = FETCH_OP;
            end
            default: state_d = FETCH_OP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH_OP;
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         op_q    <= 8'h00;
         opnd_q  <= 8'h00;
         len2_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         len2_q  <= len2_d;
         ill_q   <= ill_d;
      end
   end

   assign rom_address = pc_q[ADDR_W-1:0];
   assign pc          = pc_q;
   assign instr_valid = (state_q == HOLD);
   assign opcode      = op_q;
   assign operand     = opnd_q;
   assign instr_len2  = len2_q;
   assign instr_pc    = ipc_q;
   assign illegal     = ill_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a
// bench-side ROM walker model.
module tb_instr_fetch_unit;

   logic       clk;
   logic       reset;
   logic [6:0] rom_address;
   logic [7:0] rom_data;
   logic [7:0] pc;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] opcode;
   logic [7:0] operand;
   logic       instr_len2;
   logic [7:0] instr_pc;
   logic       illegal;
   logic       redirect;
   logic [7:0] redirect_pc;

   logic [7:0] rom [0:127];
   int checks;
   int failures;

   logic [7:0] two_b [0:14];
   logic [7:0] one_b [0:7];

   assign rom_data = rom[rom_address];

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .operand     (operand),
      .instr_len2  (instr_len2),
      .instr_pc    (instr_pc),
      .illegal     (illegal),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_len2(logic [7:0] op);
      for (int i = 0; i < 15; i++) if (two_b[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_legal(logic [7:0] op);
      for (int i = 0; i < 8; i++) if (one_b[i] == op) return 1'b1;
      return m_len2(op);
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
   endtask

   task automatic load_t1();
      clear_rom();
      rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
      rom[3] = 8'hF0; rom[4] = 8'h20; rom[5] = 8'hFE;
   endtask

   // Leaves the bench in cycle 0 (first cycle with reset high).
   task automatic do_reset();
      reset    = 1'b0;
      redirect = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, instr_valid, 0);
      chk({tag, "_pc"}, pc, 8'h00);
      chk({tag, "_addr"}, rom_address, 7'h00);
      chk({tag, "_op"}, opcode, 8'h00);
      chk({tag, "_opnd"}, operand, 8'h00);
      chk({tag, "_len2"}, instr_len2, 0);
      chk({tag, "_ipc"}, instr_pc, 8'h00);
      chk({tag, "_ill"}, illegal, 0);
   endtask

   initial begin
      logic [7:0] model_pc;
      logic [7:0] exp_pc;
      logic [7:0] tgt;
      logic [7:0] mop;
      int         s;
      int         elen;
      int         adv;
      bit         rdy;
      bit         rdr;

      checks   = 0;
      failures = 0;
      two_b = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h20,
                8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                8'h28};
      one_b = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
                8'h49};
      for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
      reset       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 8'h33;
      instr_ready = 1'b1;

      // Reset values, ROM contents and redirect ignored.
      tick();
      tick();
      chk_reset_vals("rst");

      // Back-to-back 2-byte instructions, ready tied high.
      load_t1();
      do_reset();
      instr_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         chk($sformatf("t1_valid_c%0d", c), instr_valid,
             (c == 2 || c == 5 || c == 8));
         if (c == 2) begin
            chk("t1_op0", opcode, 8'h86);
            chk("t1_opnd0", operand, 8'hAA);
            chk("t1_ipc0", instr_pc, 8'h00);
            chk("t1_len0", instr_len2, 1);
         end
         if (c == 5) begin
            chk("t1_op1", opcode, 8'h96);
            chk("t1_opnd1", operand, 8'hF0);
            chk("t1_ipc1", instr_pc, 8'h02);
         end
         if (c == 8) begin
            chk("t1_op2", opcode, 8'h20);
            chk("t1_opnd2", operand, 8'hFE);
            chk("t1_ipc2", instr_pc, 8'h04);
            chk("t1_pc2", pc, 8'h06);
         end
         tick();
      end

      // Back-pressure on a 1-byte instruction.
      clear_rom();
      rom[0] = 8'h42;
      instr_ready = 1'b0;
      do_reset();
      tick();
      for (int c = 1; c <= 5; c++) begin
         chk("t2_valid", instr_valid, 1);
         chk("t2_op", opcode, 8'h42);
         chk("t2_opnd", operand, 8'h00);
         chk("t2_len", instr_len2, 0);
         chk("t2_pc", pc, 8'h01);
         tick();
      end
      instr_ready = 1'b1;
      chk("t2_valid6", instr_valid, 1);
      tick();
      chk("t2_valid7", instr_valid, 0);
      chk("t2_addr7", rom_address, 7'h01);
      tick();
      chk("t2_valid8", instr_valid, 1);
      chk("t2_ipc8", instr_pc, 8'h01);

      // Redirect during the operand fetch drops the bundle.
      load_t1();
      instr_ready = 1'b1;
      do_reset();
      tick();
      redirect    = 1'b1;
      redirect_pc = 8'h04;
      tick();
      redirect = 1'b0;
      chk("t3_valid2", instr_valid, 0);
      chk("t3_addr2", rom_address, 7'h04);
      tick();
      chk("t3_valid3", instr_valid, 0);
      tick();
      chk("t3_valid4", instr_valid, 1);
      chk("t3_op", opcode, 8'h20);
      chk("t3_opnd", operand, 8'hFE);
      chk("t3_ipc", instr_pc, 8'h04);

      // Operand straddling the ROM wrap.
      clear_rom();
      rom[127] = 8'h88;
      rom[0]   = 8'h55;
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 8'h7F;
      tick();
      redirect = 1'b0;
      chk("t4_addr1", rom_address, 7'h7F);
      tick();
      tick();
      chk("t4_valid", instr_valid, 1);
      chk("t4_op", opcode, 8'h88);
      chk("t4_opnd", operand, 8'h55);
      chk("t4_ipc", instr_pc, 8'h7F);
      chk("t4_pc", pc, 8'h81);
      chk("t4_addr", rom_address, 7'h01);

      // Illegal opcode fetched as 1-byte.
      clear_rom();
      rom[0] = 8'hFF;
      do_reset();
      tick();
      chk("t5_valid", instr_valid, 1);
      chk("t5_ill", illegal, 1);
      chk("t5_len", instr_len2, 0);
      chk("t5_opnd", operand, 8'h00);
      chk("t5_op", opcode, 8'hFF);

      // Reset mid operand fetch beats a simultaneous redirect.
      load_t1();
      do_reset();
      tick();
      reset       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      tick();
      chk_reset_vals("t6");
      reset    = 1'b1;
      redirect = 1'b0;

      // Randomized: ROM walker model with random ready/redirect.
      for (int i = 0; i < 128; i++) begin
         if ($urandom_range(0, 3) == 0) rom[i] = 8'($urandom);
         else if ($urandom_range(0, 1) == 0)
            rom[i] = two_b[$urandom_range(0, 14)];
         else
            rom[i] = one_b[$urandom_range(0, 7)];
      end
      do_reset();
      model_pc = 8'h00;
      s = 0;
      for (int n = 0; n < 3000; n++) begin
         mop  = rom[model_pc[6:0]];
         elen = m_len2(mop) ? 2 : 1;
         adv  = (s < elen) ? s : elen;
         exp_pc = model_pc + 8'(adv);
         chk("rnd_pc", pc, exp_pc);
         chk("rnd_addr", rom_address, exp_pc[6:0]);
         chk("rnd_valid", instr_valid, (s >= elen));
         if (s >= elen) begin
            tgt = model_pc + 8'd1;
            chk("rnd_op", opcode, mop);
            chk("rnd_opnd", operand, (elen == 2) ? rom[tgt[6:0]] : 8'h00);
            chk("rnd_ipc", instr_pc, model_pc);
            chk("rnd_len", instr_len2, (elen == 2));
            chk("rnd_ill", illegal, !m_legal(mop));
         end
         rdy = ($urandom_range(0, 2) != 0);
         rdr = ($urandom_range(0, 15) == 0);
         tgt = 8'($urandom);
         instr_ready = rdy;
         redirect    = rdr;
         redirect_pc = tgt;
         tick();
         if (rdr) begin
            model_pc = tgt;
            s = 0;
         end else if (s >= elen && rdy) begin
            model_pc = model_pc + 8'(elen);
            s = 0;
         end else begin
            s++;
         end
      end
      redirect = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
